// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - PC_OP codes, fetch FSM states and branch helper for the fetch stage
package fetch_unit_pkg;

   localparam logic [3:0] PC_OP_NEXT  = 4'd0;
   localparam logic [3:0] PC_OP_J     = 4'd1;
   localparam logic [3:0] PC_OP_JR    = 4'd2;
   localparam logic [3:0] PC_OP_COP0  = 4'd3;
   localparam logic [3:0] PC_OP_BZ    = 4'd4;
   localparam logic [3:0] PC_OP_BNZ   = 4'd5;
   localparam logic [3:0] PC_OP_BG    = 4'd6;
   localparam logic [3:0] PC_OP_BGZ   = 4'd7;
   localparam logic [3:0] PC_OP_BNG   = 4'd8;
   localparam logic [3:0] PC_OP_BNGNZ = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2,
      S_ERR   = 2'd3
   } fetch_state_e;

   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/ack bus between fetch stage and imem
interface fetch_unit_if;

   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rdata
   );

endinterface

// File: rtl/fetch_unit_npc_calc.sv
// rtl/fetch_unit_npc_calc.sv - combinational next-PC and branch-condition logic
// FETCH_DELAY_SLOT_EN adds redirect_o, flagging ops whose target is deferred past a delay slot.
module fetch_unit_npc_calc
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [25:0] ins_i,
   input  logic [3:0]  pc_op_i,
   input  logic        alu_zero_i,
   input  logic        alu_neg_i,
   input  logic [31:0] rs_val_i,
   input  logic [31:0] cop0_pc_i,
   output logic [31:0] pc4_o,
`ifdef FETCH_DELAY_SLOT_EN
   output logic        redirect_o,
`endif
   output logic [31:0] target_o
);

   logic        taken;
   logic [31:0] br_target;

   assign pc4_o     = pc_i + 32'd4;
   assign br_target = pc4_o + branch_offset(ins_i[15:0]);

   always_comb begin
      taken = 1'b0;
      case (pc_op_i)
         PC_OP_BZ:    taken = alu_zero_i;
         PC_OP_BNZ:   taken = !alu_zero_i;
         PC_OP_BG:    taken = !alu_zero_i && !alu_neg_i;
         PC_OP_BGZ:   taken = !alu_neg_i;
         PC_OP_BNG:   taken = alu_zero_i || alu_neg_i;
         PC_OP_BNGNZ: taken = alu_neg_i && !alu_zero_i;
         default:     taken = 1'b0;
      endcase
   end

   // Unknown codes and not-taken branches fall through to the sequential address.
   always_comb begin
      target_o = pc4_o;
      case (pc_op_i)
         PC_OP_J:    target_o = {pc4_o[31:28], ins_i, 2'b00};
         PC_OP_JR:   target_o = rs_val_i;
         PC_OP_COP0: target_o = cop0_pc_i;
         default:    if (taken) target_o = br_target;
      endcase
   end

`ifdef FETCH_DELAY_SLOT_EN
   assign redirect_o = (pc_op_i == PC_OP_J) || (pc_op_i == PC_OP_JR) || taken;
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack FSM, instruction register
// FETCH_DELAY_SLOT_EN defers taken jump/branch targets by one (delay-slot) instruction.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
)
(
   input  logic                clk,
   input  logic                rst,
   fetch_unit_if.master        imem,
   output logic [31:0]         ins_o,
   output logic                ins_valid_o,
   output logic [31:0]         pc_o,
   output logic [31:0]         link_pc_o,
   input  logic                commit_i,
   input  logic [3:0]          pc_op_i,
   input  logic                alu_zero_i,
   input  logic                alu_neg_i,
   input  logic [31:0]         rs_val_i,
   input  logic [31:0]         cop0_pc_i,
   input  logic                cop0_redirect_i,
   output logic                fetch_adel_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ins_q, ins_d;
   logic [31:0]  pc4;
   logic [31:0]  target;
   logic [31:0]  next_pc;

`ifdef FETCH_DELAY_SLOT_EN
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic         pend_v_q, pend_v_d;
   logic         redirect;
`endif

   fetch_unit_npc_calc u_npc_calc (
      .pc_i       (pc_q),
      .ins_i      (ins_q[25:0]),
      .pc_op_i    (pc_op_i),
      .alu_zero_i (alu_zero_i),
      .alu_neg_i  (alu_neg_i),
      .rs_val_i   (rs_val_i),
      .cop0_pc_i  (cop0_pc_i),
      .pc4_o      (pc4),
`ifdef FETCH_DELAY_SLOT_EN
      .redirect_o (redirect),
`endif
      .target_o   (target)
   );

`ifdef FETCH_DELAY_SLOT_EN
   // A pending target owns the delay slot's commit, whatever that slot's own pc_op says.
   always_comb begin
      if (cop0_redirect_i) begin
         next_pc = cop0_pc_i;
      end else if (pend_v_q) begin
         next_pc = pend_pc_q;
      end else if (redirect) begin
         next_pc = pc4;
      end else begin
         next_pc = target;
      end
   end

   assign link_pc_o = pc_q + 32'd8;
`else
   assign next_pc   = cop0_redirect_i ? cop0_pc_i : target;
   assign link_pc_o = pc4;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         ins_q     <= '0;
`ifdef FETCH_DELAY_SLOT_EN
         pend_pc_q <= '0;
         pend_v_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ins_q     <= ins_d;
`ifdef FETCH_DELAY_SLOT_EN
         pend_pc_q <= pend_pc_d;
         pend_v_q  <= pend_v_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ins_d     = ins_q;
`ifdef FETCH_DELAY_SLOT_EN
      pend_pc_d = pend_pc_q;
      pend_v_d  = pend_v_q;
`endif
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (imem.ack) begin
               ins_d   = imem.rdata;
               state_d = S_VALID;
            end
         end
         S_VALID, S_ERR: begin
            if (commit_i) begin
               pc_d = next_pc;
`ifdef FETCH_DELAY_SLOT_EN
               if (cop0_redirect_i || pend_v_q) begin
                  pend_v_d = 1'b0;
               end else if (redirect) begin
                  pend_v_d  = 1'b1;
                  pend_pc_d = target;
               end
`endif
               // Misaligned target: present a nop with the error flag instead of fetching.
               if (next_pc[1:0] != 2'b00) begin
                  ins_d   = '0;
                  state_d = S_ERR;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imem.req     = (state_q == S_REQ);
   assign imem.addr    = pc_q;
   assign ins_o        = ins_q;
   assign pc_o         = pc_q;
   assign ins_valid_o  = (state_q == S_VALID) || (state_q == S_ERR);
   assign fetch_adel_o = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit (FETCH_DELAY_SLOT_EN selects the delay-slot sequence)
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } fetch_t;

   // {pc_op, alu_zero, alu_neg, taken}
   localparam logic [6:0] BR_TBL [13] = '{
      {PC_OP_BZ,    1'b1, 1'b0, 1'b1},
      {PC_OP_BZ,    1'b0, 1'b0, 1'b0},
      {PC_OP_BNZ,   1'b0, 1'b0, 1'b1},
      {PC_OP_BNZ,   1'b1, 1'b0, 1'b0},
      {PC_OP_BG,    1'b0, 1'b0, 1'b1},
      {PC_OP_BG,    1'b0, 1'b1, 1'b0},
      {PC_OP_BGZ,   1'b1, 1'b0, 1'b1},
      {PC_OP_BGZ,   1'b0, 1'b1, 1'b0},
      {PC_OP_BNG,   1'b1, 1'b0, 1'b1},
      {PC_OP_BNG,   1'b0, 1'b0, 1'b0},
      {PC_OP_BNGNZ, 1'b0, 1'b1, 1'b1},
      {PC_OP_BNGNZ, 1'b1, 1'b1, 1'b0},
      {4'hF,        1'b1, 1'b1, 1'b0}
   };

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins, pc, link_pc, rs_val, cop0_pc;
   logic        ins_valid, commit, alu_zero, alu_neg, cop0_redirect, fetch_adel;
   logic [3:0]  pc_op;

   logic        model_ack = 1'b0;
   logic [31:0] model_rdata = '0;
   int          req_cnt = 0;
   int          lat;
   logic        man_ack;
   logic [31:0] man_rdata;
   logic [31:0] mem [logic [31:0]];

   fetch_t      exp_q [$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   fetch_unit_if imem ();

   assign imem.ack   = model_ack | man_ack;
   assign imem.rdata = man_ack ? man_rdata : model_rdata;

   fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem            (imem.master),
      .ins_o           (ins),
      .ins_valid_o     (ins_valid),
      .pc_o            (pc),
      .link_pc_o       (link_pc),
      .commit_i        (commit),
      .pc_op_i         (pc_op),
      .alu_zero_i      (alu_zero),
      .alu_neg_i       (alu_neg),
      .rs_val_i        (rs_val),
      .cop0_pc_i       (cop0_pc),
      .cop0_redirect_i (cop0_redirect),
      .fetch_adel_o    (fetch_adel)
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], 16'h0002};
   endfunction

   // Memory responder: ack arrives in the lat-th cycle after req rises.
   always @(negedge clk) begin
      if (imem.req && !model_ack) begin
         req_cnt = req_cnt + 1;
         if (req_cnt == lat + 1) begin
            model_ack   = 1'b1;
            model_rdata = mem_rd(imem.addr);
         end
      end else begin
         model_ack = 1'b0;
         req_cnt   = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] a);
      exp_q.push_back(fetch_t'{pc: a, ins: mem_rd(a)});
   endtask

   task automatic wait_valid(input int max, output int n);
      fetch_t e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ins_valid && n < max);
      check("ins_valid_wait", 32'(ins_valid), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("fetch_pc", pc, e.pc);
         check("fetch_ins", ins, e.ins);
      end
   endtask

   task automatic do_commit(input logic [3:0] op, input logic z, input logic ng,
                            input logic [31:0] rs, input logic [31:0] cp0, input logic redir);
      pc_op         = op;
      alu_zero      = z;
      alu_neg       = ng;
      rs_val        = rs;
      cop0_pc       = cp0;
      cop0_redirect = redir;
      commit        = 1'b1;
      @(negedge clk);
      commit        = 1'b0;
      cop0_redirect = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] cur, wrd, nxt;
      logic [6:0]  ent;

      rst = 1'b1; commit = 1'b0; pc_op = PC_OP_NEXT; alu_zero = 1'b0; alu_neg = 1'b0;
      rs_val = '0; cop0_pc = '0; cop0_redirect = 1'b0; man_ack = 1'b0; man_rdata = '0;
      lat = 2;
      mem[32'h3000] = 32'h2001_0001;
      mem[32'h3010] = 32'h1022_FFFF;
      mem[32'h4180] = 32'h0800_0100;
      mem[32'h5000] = 32'h0800_0100;
`ifdef FETCH_DELAY_SLOT_EN
      mem[32'h3000] = 32'h0800_0100;
`endif
      repeat (2) @(negedge clk);
      check("rst_req", 32'(imem.req), 32'd0);
      check("rst_addr", imem.addr, 32'h0000_3000);
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_ins", ins, 32'd0);
      check("rst_valid", 32'(ins_valid), 32'd0);
      check("rst_adel", 32'(fetch_adel), 32'd0);

      expect_fetch(32'h3000);
      rst = 1'b0;
      @(negedge clk);
      check("req_after_rst", 32'(imem.req), 32'd1);
      check("addr_after_rst", imem.addr, 32'h0000_3000);
      wait_valid(20, n);
      check("req_to_valid_lat2", n, 32'd3);

`ifdef FETCH_DELAY_SLOT_EN
      check("link_pc_ds", link_pc, 32'h0000_3008);
      lat = 1;
      expect_fetch(32'h3004);
      do_commit(PC_OP_J, 1'b0, 1'b0, '0, '0, 1'b0);
      check("ds_slot_addr", imem.addr, 32'h0000_3004);
      wait_valid(20, n);
      check("link_pc_ds_slot", link_pc, 32'h0000_300C);
      expect_fetch(32'h0400);
      do_commit(PC_OP_NEXT, 1'b0, 1'b0, '0, '0, 1'b0);
      wait_valid(20, n);
      // Taken branch at 0x400 defers 0x40C; cop0 redirect at the slot discards it.
      expect_fetch(32'h0404);
      do_commit(PC_OP_BZ, 1'b1, 1'b0, '0, '0, 1'b0);
      wait_valid(20, n);
      expect_fetch(32'h5000);
      do_commit(PC_OP_NEXT, 1'b0, 1'b0, '0, 32'h5000, 1'b1);
      wait_valid(20, n);
      mem[32'h5000] = 32'h2001_0001;
      expect_fetch(32'h5004);
      do_commit(PC_OP_NEXT, 1'b0, 1'b0, '0, '0, 1'b0);
      wait_valid(20, n);
`else
      check("link_pc", link_pc, 32'h0000_3004);

      lat = 1;
      expect_fetch(32'h3004);
      do_commit(PC_OP_NEXT, 1'b0, 1'b0, '0, '0, 1'b0);
      check("next_req", 32'(imem.req), 32'd1);
      check("next_addr", imem.addr, 32'h0000_3004);
      check("valid_drop", 32'(ins_valid), 32'd0);
      wait_valid(20, n);
      check("commit_to_valid", n + 1, 32'd3);

      expect_fetch(32'h3010);
      do_commit(PC_OP_JR, 1'b0, 1'b0, 32'h3010, '0, 1'b0);
      wait_valid(20, n);
      expect_fetch(32'h3010);
      do_commit(PC_OP_BZ, 1'b1, 1'b0, '0, '0, 1'b0);
      wait_valid(20, n);
      expect_fetch(32'h3014);
      do_commit(PC_OP_BZ, 1'b0, 1'b0, '0, '0, 1'b0);
      wait_valid(20, n);

      cur = 32'h3014;
      for (int i = 0; i < 13; i++) begin
         ent = BR_TBL[i];
         wrd = mem_rd(cur);
         nxt = ent[0] ? (cur + 32'd4 + {{14{wrd[15]}}, wrd[15:0], 2'b00}) : (cur + 32'd4);
         expect_fetch(nxt);
         do_commit(ent[6:3], ent[2], ent[1], '0, '0, 1'b0);
         wait_valid(20, n);
         cur = nxt;
      end

      do_commit(PC_OP_JR, 1'b0, 1'b0, 32'h3042, '0, 1'b0);
      check("adel_flag", 32'(fetch_adel), 32'd1);
      check("adel_ins", ins, 32'd0);
      check("adel_valid", 32'(ins_valid), 32'd1);
      check("adel_pc", pc, 32'h0000_3042);
      repeat (3) @(negedge clk);
      check("adel_no_req", 32'(imem.req), 32'd0);
      expect_fetch(32'h4180);
      do_commit(PC_OP_COP0, 1'b0, 1'b0, '0, 32'h4180, 1'b0);
      check("adel_clear", 32'(fetch_adel), 32'd0);
      wait_valid(20, n);

      expect_fetch(32'h5000);
      do_commit(PC_OP_J, 1'b0, 1'b0, '0, 32'h5000, 1'b1);
      wait_valid(20, n);
      expect_fetch(32'h0400);
      do_commit(PC_OP_J, 1'b0, 1'b0, '0, '0, 1'b0);
      wait_valid(20, n);

      lat = 3;
      do_commit(PC_OP_NEXT, 1'b0, 1'b0, '0, '0, 1'b0);
      check("fetch404_addr", imem.addr, 32'h0000_0404);
      pc_op = PC_OP_JR; rs_val = 32'h9000; commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      check("commit_in_req_ignored", imem.addr, 32'h0000_0404);
      rst = 1'b1;
      #1;
      check("rst_drops_req", 32'(imem.req), 32'd0);
      check("rst_mid_addr", imem.addr, 32'h0000_3000);
      check("rst_mid_ins", ins, 32'd0);
      @(negedge clk);
      rst = 1'b0; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      man_ack = 1'b0;
      check("late_ack_ignored", 32'(ins_valid), 32'd0);
      check("refetch_addr", imem.addr, 32'h0000_3000);
      expect_fetch(32'h3000);
      wait_valid(20, n);
      check("refetch_lat3", n, 32'd4);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
